// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-buffered character feeder that hands one character at a time to a UART transmitter
module uart_tx_feeder #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 8
) (
  input  logic                       bclk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_BITS-1:0]       wr_data,
  input  logic                       clr_ovf,
  input  logic                       txd_done,
  output logic                       txd_startH,
  output logic [DATA_BITS-1:0]       tx_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  state_t state, state_nxt;
  logic [AW:0] rd_ptr, wr_ptr;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic push, pop;
  assign empty = rd_ptr == wr_ptr;
  assign full  = rd_ptr[AW-1:0] == wr_ptr[AW-1:0] && rd_ptr[AW] != wr_ptr[AW];
  assign count = wr_ptr - rd_ptr;
  assign push  = wr_en && !full;
  assign pop   = state == IDLE && !empty;
  // storage array needs no reset; only the pointers define valid entries
  always_ff @(posedge bclk)
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  // pointers, overflow flag and the held transmit character
  always_ff @(posedge bclk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
      tx_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr[AW-1:0]];
      end
      overflow <= (wr_en && full) ? 1'b1 : clr_ovf ? 1'b0 : overflow;
    end
  // state register
  always_ff @(posedge bclk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  // next state: txd_done only matters once the frame is in SEND
  always_comb
    state_nxt = state == IDLE ? (empty ? IDLE : LOAD) :
                state == LOAD ? SEND :
                txd_done      ? IDLE : SEND;
  // outputs decoded from state
  always_comb begin
    txd_startH = state == LOAD;
    busy       = state != IDLE;
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: randomized and directed checking of uart_tx_feeder against a queue-based reference
module tb_uart_tx_feeder;
  localparam int DEPTH = 8;
  logic       bclk = 1'b0;
  logic       rst_n, wr_en, clr_ovf, txd_done;
  logic [7:0] wr_data;
  logic       txd_startH, full, empty, busy, overflow;
  logic [7:0] tx_data;
  logic [3:0] count;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mq[$];
  int         m_phase;
  logic       m_ovf;
  logic [7:0] m_tx;

  uart_tx_feeder #(.DATA_BITS(8), .DEPTH(DEPTH)) dut (
    .bclk(bclk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .txd_done(txd_done), .txd_startH(txd_startH), .tx_data(tx_data), .full(full),
    .empty(empty), .count(count), .busy(busy), .overflow(overflow)
  );

  always #5 bclk = ~bclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), mq.size());
    chk("empty", 32'(empty), mq.size() == 0);
    chk("full", 32'(full), mq.size() == DEPTH);
    chk("busy", 32'(busy), m_phase != 0);
    chk("txd_startH", 32'(txd_startH), m_phase == 1);
    chk("tx_data", 32'(tx_data), 32'(m_tx));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("count_max", 32'(count <= DEPTH), 1);
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 0;
    m_ovf = 1'b0;
    m_tx = '0;
  endtask

  // phase 0: no frame, 1: start cycle, 2: awaiting end-of-frame
  task automatic model_edge(input logic wr, input logic [7:0] d, input logic clr, input logic done);
    bit fullm, popm;
    fullm = mq.size() == DEPTH;
    popm = m_phase == 0 && mq.size() != 0;
    if (wr && fullm) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (m_phase == 0) m_phase = popm ? 1 : 0;
    else if (m_phase == 1) m_phase = 2;
    else m_phase = done ? 0 : 2;
    if (popm) m_tx = mq.pop_front();
    if (wr && !fullm) mq.push_back(d);
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic clr, input logic done);
    wr_en = wr;
    wr_data = d;
    clr_ovf = clr;
    txd_done = done;
    @(posedge bclk);
    model_edge(wr, d, clr, done);
    #1;
    check_all();
    wr_en = 1'b0;
    clr_ovf = 1'b0;
    txd_done = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && (mq.size() != 0 || m_phase != 0); i++)
      step(1'b0, 8'h00, 1'b0, m_phase == 2);
    chk("drained", 32'(empty && !busy), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    clr_ovf = 1'b0;
    txd_done = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge bclk) rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("lat_count1", 32'(count), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("lat_start", 32'(txd_startH), 1);
    chk("lat_data", 32'(tx_data), 32'hA5);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("held_data", 32'(tx_data), 32'hA5);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("burst_ovf", 32'(overflow), 1);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("set_wins", 32'(overflow), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf_clr", 32'(overflow), 0);
    drain();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    drain();
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (400) step($urandom_range(99) < 55, 8'($urandom), $urandom_range(9) == 0, $urandom_range(99) < 35);
    drain();
    for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_rst_busy", 32'(busy && !txd_startH), 1);
    chk("pre_rst_count", 32'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge bclk) rst_n = 1'b1;
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_start", 32'(txd_startH), 1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
